// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
// Holds the writeback-source encoding, branch-type constants, the
// multiplier-tracking FSM state type and a register-match helper.
package mips_pkg;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_PC8  = 3'd2;
  localparam logic [2:0] WB_MULT = 3'd3;

  localparam logic [1:0] BR_NONE = 2'd0;

  typedef enum logic [1:0] {
    MIDLE = 2'd0,
    MBUSY = 2'd1,
    MERR  = 2'd2
  } mult_state_e;

  // Register $0 is hardwired to zero, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_mult_fsm.sv
// Multi-cycle multiplier tracker: IDLE/BUSY/ERR state, a watchdog timer
// counting BUSY cycles without a done pulse, and a sticky timeout flag.
module hazard_mult_fsm
  import mips_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mult_start,
  input  logic mult_done,
  output logic mult_busy,
  output logic mult_err
);

  localparam int TW = (MULT_TIMEOUT > 2) ? $clog2(MULT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MULT_TIMEOUT - 1);

  mult_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  // Next-state logic: a done pulse always wins, a start while busy is ignored.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      MIDLE: begin
        if (mult_start) begin
          state_d = MBUSY;
          timer_d = '0;
        end
      end
      MBUSY: begin
        if (mult_done) begin
          state_d = MIDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = MERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      MERR: begin
        if (mult_done) begin
          state_d = MIDLE;
        end
      end
      default: state_d = MIDLE;
    endcase
  end

  // State, watchdog timer and sticky error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MIDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign mult_busy = (state_q != MIDLE);
  assign mult_err  = err_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: operand
// forwarding selects, load-use / branch / multiplier stalls, E-stage flush.
// Optional feature macro HAZARD_PERF_EN adds saturating performance counters
// (stall_cnt, flush_cnt, mult_cnt); without it those ports do not exist.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [1:0] branchD,
  input  logic       jumpD,
  input  logic       multstartD,
  input  logic       mfhiloD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [2:0] WBSrcE,
  input  logic [2:0] WBSrcM,
  input  logic       MultStartE,
  input  logic       MultDoneE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mult_busy,
  output logic       mult_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mult_cnt
`endif
);

  logic mult_busy_raw;
  logic mult_err_raw;
  logic lwstall, brstall, mstall, stall;
  logic [1:0] fwd_ae, fwd_be;
  logic fwd_ad, fwd_bd;

  // A jump resolves in D without reading registers, so it never stalls.
  logic unused_jump;
  assign unused_jump = jumpD;

  hazard_mult_fsm #(
    .MULT_TIMEOUT(MULT_TIMEOUT)
  ) u_mult_fsm (
    .clk       (clk),
    .rst_n     (rst),
    .mult_start(MultStartE),
    .mult_done (MultDoneE),
    .mult_busy (mult_busy_raw),
    .mult_err  (mult_err_raw)
  );

  // Forwarding selects and stall sources; the younger M result beats W.
  always_comb begin
    fwd_ae = 2'b00;
    fwd_be = 2'b00;
    if (RegWriteM && reg_match(WriteRegM, RsE)) begin
      fwd_ae = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RsE)) begin
      fwd_ae = 2'b01;
    end
    if (RegWriteM && reg_match(WriteRegM, RtE)) begin
      fwd_be = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RtE)) begin
      fwd_be = 2'b01;
    end
    fwd_ad = RegWriteM && reg_match(WriteRegM, RsD);
    fwd_bd = RegWriteM && reg_match(WriteRegM, RtD);

    lwstall = (WBSrcE == WB_MEM) && RegWriteE &&
              (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));
    brstall = (branchD != BR_NONE) &&
              ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
               ((WBSrcM == WB_MEM) && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    mstall  = (mult_busy_raw || MultStartE) && (mfhiloD || multstartD);
    stall   = lwstall || brstall || mstall;
  end

  // Every output is forced low while reset is asserted.
  always_comb begin
    stallF    = rst && stall;
    stallD    = rst && stall;
    flushE    = rst && stall;
    forwardAD = rst && fwd_ad;
    forwardBD = rst && fwd_bd;
    forwardAE = rst ? fwd_ae : 2'b00;
    forwardBE = rst ? fwd_be : 2'b00;
    mult_busy = rst && mult_busy_raw;
    mult_err  = rst && mult_err_raw;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] mult_cnt_q, mult_cnt_d;

  // Saturating increments so a long run never wraps back to small values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mult_cnt_d  = mult_cnt_q;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flushE && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (MultDoneE && (mult_cnt_q != {CNT_W{1'b1}})) mult_cnt_d = mult_cnt_q + CNT_W'(1);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mult_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mult_cnt_q  <= mult_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mult_cnt  = mult_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic compared against a behavioural model of the hazard rules.
// Build with HAZARD_PERF_EN defined to also cover the performance counters.
module tb_hazard_controller;
  import mips_pkg::*;

  localparam int T  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk, rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic [1:0] branchD;
  logic       jumpD, multstartD, mfhiloD;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [2:0] WBSrcE, WBSrcM;
  logic       MultStartE, MultDoneE;
  logic       stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       mult_busy, mult_err;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt, mult_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_busy;
  int m_wait;
  bit m_err;
  int m_stall_cnt, m_flush_cnt, m_mult_cnt;

  hazard_controller #(.MULT_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .branchD(branchD), .jumpD(jumpD),
    .multstartD(multstartD), .mfhiloD(mfhiloD),
    .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WBSrcE(WBSrcE), .WBSrcM(WBSrcM),
    .MultStartE(MultStartE), .MultDoneE(MultDoneE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mult_busy(mult_busy), .mult_err(mult_err)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mult_cnt(mult_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus legality: a start may never meet a done while a multiply is in flight.
  always @(negedge clk) begin
    #2;
    assert (!(rst && m_busy && MultStartE && MultDoneE))
      else $error("[TB] illegal start+done while multiplier busy");
  end

  function automatic bit same(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] expFwdE(input logic [4:0] src);
    if (RegWriteM && same(WriteRegM, src)) return 2'b10;
    if (RegWriteW && same(WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit lw, br, ms;
    bit readsE, readsM;
    readsE = same(WriteRegE, RsD) || same(WriteRegE, RtD);
    readsM = same(WriteRegM, RsD) || same(WriteRegM, RtD);
    lw = (WBSrcE == WB_MEM) && RegWriteE && readsE;
    br = (branchD != 2'd0) && ((RegWriteE && readsE) || ((WBSrcM == WB_MEM) && readsM));
    ms = (m_busy || MultStartE) && (mfhiloD || multstartD);
    return lw || br || ms;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_wait = 0; m_err = 0;
    m_stall_cnt = 0; m_flush_cnt = 0; m_mult_cnt = 0;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic modelTick();
    bit s;
    if (!rst) return;
    s = expStall();
    if (s && m_stall_cnt < CMAX) m_stall_cnt++;
    if (s && m_flush_cnt < CMAX) m_flush_cnt++;
    if (MultDoneE && m_mult_cnt < CMAX) m_mult_cnt++;
    if (!m_busy) begin
      if (MultStartE) begin
        m_busy = 1;
        m_wait = 0;
      end
    end else if (MultDoneE) begin
      m_busy = 0;
    end else begin
      m_wait++;
      if (m_wait >= T) m_err = 1;
    end
  endtask

  task automatic checkAll(input string ph);
    bit s;
    s = rst && expStall();
    checkOutput({ph, " fwdAE"}, 32'(forwardAE), rst ? 32'(expFwdE(RsE)) : 32'd0);
    checkOutput({ph, " fwdBE"}, 32'(forwardBE), rst ? 32'(expFwdE(RtE)) : 32'd0);
    checkOutput({ph, " fwdAD"}, 32'(forwardAD), 32'(rst && RegWriteM && same(WriteRegM, RsD)));
    checkOutput({ph, " fwdBD"}, 32'(forwardBD), 32'(rst && RegWriteM && same(WriteRegM, RtD)));
    checkOutput({ph, " stallF"}, 32'(stallF), 32'(s));
    checkOutput({ph, " stallD"}, 32'(stallD), 32'(s));
    checkOutput({ph, " flushE"}, 32'(flushE), 32'(s));
    checkOutput({ph, " busy"}, 32'(mult_busy), 32'(rst && m_busy));
    checkOutput({ph, " err"}, 32'(mult_err), 32'(rst && m_err));
`ifdef HAZARD_PERF_EN
    checkOutput({ph, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
    checkOutput({ph, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
    checkOutput({ph, " mult_cnt"}, 32'(mult_cnt), 32'(m_mult_cnt));
`endif
  endtask

  // Inputs are set at the falling edge; check mid-low-phase, then cross one rising edge.
  task automatic applyStimulus(input string ph);
    #1;
    checkAll(ph);
    @(posedge clk);
    modelTick();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    branchD = 0; jumpD = 0; multstartD = 0; mfhiloD = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    WBSrcE = WB_ALU; WBSrcM = WB_ALU;
    MultStartE = 0; MultDoneE = 0;
  endtask

  task automatic randomInputs();
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    WBSrcE = 3'($urandom_range(0, 3)); WBSrcM = 3'($urandom_range(0, 3));
    branchD = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    jumpD = 1'($urandom);
    multstartD = ($urandom_range(0, 5) == 0);
    mfhiloD = ($urandom_range(0, 5) == 0);
    MultStartE = ($urandom_range(0, 5) == 0);
    MultDoneE = ($urandom_range(0, 7) == 0);
    if (m_busy && MultStartE) MultDoneE = 0;
  endtask

  initial begin
    rst = 1'b0;
    clearInputs();
    modelReset();
    @(negedge clk);
    applyStimulus("reset");
    rst = 1'b1;

    // 1: M beats W for the same source, W used once M stops writing
    RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    #1 checkOutput("t1 fwdAE M", 32'(forwardAE), 32'd2);
    applyStimulus("t1a");
    RegWriteM = 0;
    #1 checkOutput("t1 fwdAE W", 32'(forwardAE), 32'd1);
    applyStimulus("t1b");

    // 2: load-use stall, and $0 destination never stalls
    clearInputs();
    WBSrcE = WB_MEM; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    #1 checkOutput("t2 lwstall", 32'(stallF), 32'd1);
    applyStimulus("t2a");
    WriteRegE = 0; RtD = 0;
    #1 checkOutput("t2 reg0", 32'(stallF), 32'd0);
    applyStimulus("t2b");

    // 3: branch waits on E producer, then forwards from M
    clearInputs();
    branchD = 2'd1; RsD = 9; RegWriteE = 1; WriteRegE = 9;
    #1 checkOutput("t3 brstall", 32'(stallD), 32'd1);
    applyStimulus("t3a");
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 9; WBSrcM = WB_ALU;
    #1 checkOutput("t3 nostall", 32'(stallD), 32'd0);
    checkOutput("t3 fwdAD", 32'(forwardAD), 32'd1);
    applyStimulus("t3b");

    // 4: mfhi waits for the multiply, released the cycle after done
    clearInputs();
    MultStartE = 1; mfhiloD = 1;
    #1 checkOutput("t4 c0 stall", 32'(stallF), 32'd1);
    checkOutput("t4 c0 busy", 32'(mult_busy), 32'd0);
    applyStimulus("t4c0");
    MultStartE = 0;
    for (int i = 1; i <= 5; i++) begin
      MultDoneE = (i == 5);
      #1 checkOutput($sformatf("t4 c%0d busy", i), 32'(mult_busy), 32'd1);
      checkOutput($sformatf("t4 c%0d stall", i), 32'(flushE), 32'd1);
      applyStimulus($sformatf("t4c%0d", i));
    end
    MultDoneE = 0;
    #1 checkOutput("t4 c6 busy", 32'(mult_busy), 32'd0);
    checkOutput("t4 c6 stall", 32'(stallF), 32'd0);
    applyStimulus("t4c6");

    // 5: watchdog fires after exactly T busy cycles and stays set
    clearInputs();
    MultStartE = 1;
    applyStimulus("t5start");
    MultStartE = 0;
    for (int i = 1; i <= T; i++) begin
      #1 checkOutput($sformatf("t5 c%0d err", i), 32'(mult_err), 32'd0);
      applyStimulus($sformatf("t5c%0d", i));
    end
    #1 checkOutput("t5 err set", 32'(mult_err), 32'd1);
    MultDoneE = 1;
    applyStimulus("t5done");
    MultDoneE = 0;
    #1 checkOutput("t5 idle", 32'(mult_busy), 32'd0);
    checkOutput("t5 err sticky", 32'(mult_err), 32'd1);
    applyStimulus("t5after");

    // 6: asynchronous reset in the middle of a multiply
    clearInputs();
    MultStartE = 1; mfhiloD = 1;
    applyStimulus("t6start");
    MultStartE = 0;
    applyStimulus("t6busy");
    #2 rst = 1'b0;
    #1 checkOutput("t6 busy", 32'(mult_busy), 32'd0);
    checkOutput("t6 stall", 32'(stallF), 32'd0);
`ifdef HAZARD_PERF_EN
    checkOutput("t6 stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    modelReset();
    @(negedge clk);
    applyStimulus("t6inrst");
    rst = 1'b1;

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      randomInputs();
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b0;
        #1 modelReset();
        checkAll($sformatf("rnd%0d rst", n));
        @(negedge clk);
        rst = 1'b1;
      end else begin
        applyStimulus($sformatf("rnd%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
